player_motion: RTL and testbench

- Parametrised successor to the single-player wrapper: arbitrates NUM_CH decoded controller channels (SNES/NES, IR, PS2, ...), selected by Choice.
- Latches the selected channel's direction on its Readable strobe; steps a bounded X/Y position at a divided tick rate.
- Feeds the renderer with full-width coordinates instead of 1-bit flags.
- Sits between the per-controller input decoders and GameLogic/renderer.

---
 rtl/player_motion_pkg.sv | 35 +++
 rtl/player_motion_axis_stepper.sv | 50 +++++
 rtl/player_motion.sv | 212 +++++++++++++++++++++
 tb/tb_player_motion.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/player_motion_pkg.sv
// Shared types and constants for the player motion block.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package player_pkg;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FLUSH = 2'd2
    } motion_state_t;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;

    // Step size is 1, 2 or 4, so three bits carry it.
    localparam int STEP_W = 3;

    // Opposite pairs cancel, so the result never asks for both senses on one axis.
    function automatic dir_t net_dir(input dir_t raw);
        dir_t n;
        n.up    = raw.up    & ~raw.down;
        n.down  = raw.down  & ~raw.up;
        n.left  = raw.left  & ~raw.right;
        n.right = raw.right & ~raw.left;
        return n;
    endfunction

endpackage

// File: rtl/player_motion_axis_stepper.sv
// Next coordinate on one axis from inc/dec and step size, clamped or wrapped at 0..MAX.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module axis_stepper
    import player_pkg::*;
#(
    parameter int W    = 10,
    parameter int MAX  = 639,
    parameter int WRAP = 0
) (
    input  logic [W-1:0]      cur,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      nxt,
    output logic              changed
);

    localparam logic [W:0] MAX_G  = (W+1)'(MAX);
    localparam logic [W:0] SPAN_G = (W+1)'(MAX + 1);

    logic [W:0] cur_g;
    logic [W:0] step_g;
    logic [W:0] sum_g;
    logic [W:0] dif_g;

    // One guard bit above the coordinate exposes overflow past MAX and underflow below 0.
    always_comb begin
        cur_g  = {1'b0, cur};
        step_g = (W+1)'(step);
        sum_g  = cur_g + step_g;
        dif_g  = cur_g - step_g;
        nxt    = cur;
        if (inc && !dec) begin
            if (sum_g > MAX_G) begin
                nxt = (WRAP != 0) ? W'(sum_g - SPAN_G) : W'(MAX_G);
            end else begin
                nxt = sum_g[W-1:0];
            end
        end else if (dec && !inc) begin
            if (dif_g[W]) begin
                nxt = (WRAP != 0) ? W'(cur_g + SPAN_G - step_g) : '0;
            end else begin
                nxt = dif_g[W-1:0];
            end
        end
        changed = (nxt != cur);
    end

endmodule

// File: rtl/player_motion.sv
// Selects one of NUM_CH controller channels, latches its direction and steps X/Y each move tick.
// Latency: direction latched 1 cycle after strobe; X/Y and Step update MOVE_DIV cycles after entering HELD.
// Backpressure: none; strobes are sampled every cycle. PLAYER_ACCEL_EN enables the 1->2->4 step ramp.
module player_motion
    import player_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CSEL_W   = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MAX    = SCREEN_Y_MAX,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int MOVE_DIV = 416667,
    parameter int HOLD_CYC = 1666667,
    parameter int WRAP     = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [CSEL_W-1:0] Choice,
    input  logic [NUM_CH-1:0] ChUp,
    input  logic [NUM_CH-1:0] ChDown,
    input  logic [NUM_CH-1:0] ChLeft,
    input  logic [NUM_CH-1:0] ChRight,
    input  logic [NUM_CH-1:0] ChReadable,
    output logic [X_W-1:0]    X,
    output logic [Y_W-1:0]    Y,
    output logic              Moving,
    output logic              Step
);

    localparam int SEL_N  = 2 ** CSEL_W;
    localparam int TICK_W = $clog2(MOVE_DIV);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    // Channel vectors padded to the full Choice range so out-of-range indices read zero.
    logic [SEL_N-1:0] up_pad, dn_pad, lf_pad, rt_pad, rd_pad;
    assign up_pad = SEL_N'(ChUp);
    assign dn_pad = SEL_N'(ChDown);
    assign lf_pad = SEL_N'(ChLeft);
    assign rt_pad = SEL_N'(ChRight);
    assign rd_pad = SEL_N'(ChReadable);

    motion_state_t       state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic                step_q, step_d;
    logic [CSEL_W-1:0]   choice_q;

    dir_t                raw_dir, net;
    logic                sel_vld, strobe, net_nz, choice_chg, tick_wrap, do_step;
    logic [X_W-1:0]      x_nxt;
    logic [Y_W-1:0]      y_nxt;
    logic                x_chg, y_chg;
    logic [STEP_W-1:0]   step_sz;

    // Decode the selected channel's strobe and its cancelled direction.
    always_comb begin
        sel_vld       = (int'(Choice) < NUM_CH);
        strobe        = sel_vld && rd_pad[Choice];
        raw_dir.up    = up_pad[Choice];
        raw_dir.down  = dn_pad[Choice];
        raw_dir.left  = lf_pad[Choice];
        raw_dir.right = rt_pad[Choice];
        net           = net_dir(raw_dir);
        net_nz        = |net;
        choice_chg    = (Choice != choice_q);
        tick_wrap     = (state_q == HELD) && (tick_q == TICK_LAST);
        do_step       = tick_wrap && !choice_chg;
    end

    // Next-state, latched direction, counters and position update.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        x_d     = x_q;
        y_d     = y_q;
        step_d  = 1'b0;
        // A tick steps with the direction latched before any same-cycle strobe.
        if (do_step) begin
            x_d    = x_nxt;
            y_d    = y_nxt;
            step_d = x_chg | y_chg;
        end
        if (choice_chg) begin
            state_d = FLUSH;
            dir_d   = '0;
            tick_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe && net_nz) begin
                        state_d = HELD;
                        dir_d   = net;
                    end
                end
                HELD: begin
                    tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                    if ((strobe && !net_nz) || (!strobe && hold_q == HOLD_LAST)) begin
                        state_d = IDLE;
                        dir_d   = '0;
                        tick_d  = '0;
                        hold_d  = '0;
                    end else if (strobe) begin
                        dir_d  = net;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Main register bank; Choice is tracked so a change can be detected next cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            dir_q    <= '0;
            tick_q   <= '0;
            hold_q   <= '0;
            x_q      <= X_W'(X_INIT);
            y_q      <= Y_W'(Y_INIT);
            step_q   <= 1'b0;
            choice_q <= Choice;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            x_q      <= x_d;
            y_q      <= y_d;
            step_q   <= step_d;
            choice_q <= Choice;
        end
    end

`ifdef PLAYER_ACCEL_EN
    logic [3:0] ramp_q, ramp_d;
    logic [1:0] lvl_q, lvl_d;

    // Ramp level rises after every 16 ticks of an unchanged held direction.
    always_comb begin
        ramp_d = ramp_q;
        lvl_d  = lvl_q;
        if (state_d != HELD || dir_d != dir_q) begin
            ramp_d = '0;
            lvl_d  = '0;
        end else if (tick_wrap) begin
            if (ramp_q == 4'd15) begin
                ramp_d = '0;
                if (lvl_q != 2'd2) begin
                    lvl_d = lvl_q + 1'b1;
                end
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    // Ramp registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ramp_q <= '0;
            lvl_q  <= '0;
        end else begin
            ramp_q <= ramp_d;
            lvl_q  <= lvl_d;
        end
    end

    assign step_sz = STEP_W'(1) << lvl_q;
`else
    assign step_sz = STEP_W'(1);
`endif

    axis_stepper #(.W(X_W), .MAX(X_MAX), .WRAP(WRAP)) u_x_axis (
        .cur     (x_q),
        .inc     (dir_q.right),
        .dec     (dir_q.left),
        .step    (step_sz),
        .nxt     (x_nxt),
        .changed (x_chg)
    );

    axis_stepper #(.W(Y_W), .MAX(Y_MAX), .WRAP(WRAP)) u_y_axis (
        .cur     (y_q),
        .inc     (dir_q.down),
        .dec     (dir_q.up),
        .step    (step_sz),
        .nxt     (y_nxt),
        .changed (y_chg)
    );

    assign X      = x_q;
    assign Y      = y_q;
    assign Moving = (state_q == HELD);
    assign Step   = step_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: four instances with different edge/hold settings share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each check is an immediate assertion; the summary reports passed/total.
module tb_player_motion;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] Choice;
    logic [2:0] ChUp, ChDown, ChLeft, ChRight, ChReadable;

    logic [9:0] x_m, x_c, x_w, x_h;
    logic [8:0] y_m, y_c, y_w, y_h;
    logic       mv_m, mv_c, mv_w, mv_h;
    logic       st_m, st_c, st_w, st_h;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 Clock = ~Clock;

    // Main instance: centre start, long hold, clamping.
    player_motion #(.MOVE_DIV(4), .HOLD_CYC(1000), .X_INIT(320), .Y_INIT(240), .WRAP(0)) u_main (
        .Clock(Clock), .Reset(Reset), .Choice(Choice), .ChUp(ChUp), .ChDown(ChDown),
        .ChLeft(ChLeft), .ChRight(ChRight), .ChReadable(ChReadable),
        .X(x_m), .Y(y_m), .Moving(mv_m), .Step(st_m));

    // Near right edge, clamping.
    player_motion #(.MOVE_DIV(4), .HOLD_CYC(1000), .X_INIT(638), .Y_INIT(240), .WRAP(0)) u_clamp (
        .Clock(Clock), .Reset(Reset), .Choice(Choice), .ChUp(ChUp), .ChDown(ChDown),
        .ChLeft(ChLeft), .ChRight(ChRight), .ChReadable(ChReadable),
        .X(x_c), .Y(y_c), .Moving(mv_c), .Step(st_c));

    // Near right edge, wrapping.
    player_motion #(.MOVE_DIV(4), .HOLD_CYC(1000), .X_INIT(638), .Y_INIT(240), .WRAP(1)) u_wrap (
        .Clock(Clock), .Reset(Reset), .Choice(Choice), .ChUp(ChUp), .ChDown(ChDown),
        .ChLeft(ChLeft), .ChRight(ChRight), .ChReadable(ChReadable),
        .X(x_w), .Y(y_w), .Moving(mv_w), .Step(st_w));

    // Short hold timeout.
    player_motion #(.MOVE_DIV(4), .HOLD_CYC(10), .X_INIT(320), .Y_INIT(240), .WRAP(0)) u_hold (
        .Clock(Clock), .Reset(Reset), .Choice(Choice), .ChUp(ChUp), .ChDown(ChDown),
        .ChLeft(ChLeft), .ChRight(ChRight), .ChReadable(ChReadable),
        .X(x_h), .Y(y_h), .Moving(mv_h), .Step(st_h));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One-cycle strobe; direction vectors are per-channel bit masks.
    task automatic strobe(input logic [2:0] rd, input logic [2:0] up, input logic [2:0] dn,
                          input logic [2:0] lf, input logic [2:0] rt);
        ChReadable = rd;
        ChUp       = up;
        ChDown     = dn;
        ChLeft     = lf;
        ChRight    = rt;
        cyc(1);
        ChReadable = '0;
        ChUp       = '0;
        ChDown     = '0;
        ChLeft     = '0;
        ChRight    = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        Reset      = 1'b1;
        Choice     = 2'd0;
        ChUp       = '0;
        ChDown     = '0;
        ChLeft     = '0;
        ChRight    = '0;
        ChReadable = '0;

        // Reset state.
        cyc(2);
        check("rst_x", 32'(x_m), 320);
        check("rst_y", 32'(y_m), 240);
        check("rst_moving", 32'(mv_m), 0);
        check("rst_step", 32'(st_m), 0);
        check("rst_x_clamp", 32'(x_c), 638);
        Reset = 1'b0;
        cyc(2);
        check("idle_x", 32'(x_m), 320);

        // Single Right strobe on ch0; all instances see it.
        strobe(3'b001, 3'b000, 3'b000, 3'b000, 3'b001);
        check("right_moving", 32'(mv_m), 1);
        check("right_x0", 32'(x_m), 320);
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            case (c)
                3: begin
                    check("right_x_pre_tick", 32'(x_m), 320);
                    check("right_step_pre", 32'(st_m), 0);
                end
                4: begin
                    check("right_x1", 32'(x_m), 321);
                    check("right_step1", 32'(st_m), 1);
                    check("right_y1", 32'(y_m), 240);
                    check("clamp_x1", 32'(x_c), 639);
                    check("clamp_step1", 32'(st_c), 1);
                    check("wrap_x1", 32'(x_w), 639);
                end
                5: check("right_step_low", 32'(st_m), 0);
                8: begin
                    check("right_x2", 32'(x_m), 322);
                    check("right_step2", 32'(st_m), 1);
                    check("clamp_x2", 32'(x_c), 639);
                    check("clamp_step_blocked", 32'(st_c), 0);
                    check("wrap_x2", 32'(x_w), 0);
                    check("wrap_step2", 32'(st_w), 1);
                    check("hold_x2", 32'(x_h), 322);
                end
                9:  check("hold_moving_9", 32'(mv_h), 1);
                10: begin
                    check("hold_moving_10", 32'(mv_h), 0);
                    check("hold_x_final", 32'(x_h), 322);
                end
                12: begin
                    check("right_x3", 32'(x_m), 323);
                    check("right_step3", 32'(st_m), 1);
                    check("right_y3", 32'(y_m), 240);
                    check("hold_x_still", 32'(x_h), 322);
                end
                default: ;
            endcase
        end

        // Reset while moving returns to reset values.
        do_reset();
        check("midrst_x", 32'(x_m), 320);
        check("midrst_moving", 32'(mv_m), 0);
        check("midrst_wrap_x", 32'(x_w), 638);
        Reset = 1'b0;
        cyc(1);

        // Up&Down&Left: only X decrements; then all four -> IDLE.
        strobe(3'b001, 3'b001, 3'b001, 3'b001, 3'b000);
        check("udl_moving", 32'(mv_m), 1);
        cyc(4);
        check("udl_x", 32'(x_m), 319);
        check("udl_y", 32'(y_m), 240);
        check("udl_step", 32'(st_m), 1);
        check("udl_clamp_x", 32'(x_c), 637);
        strobe(3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
        check("all4_moving", 32'(mv_m), 0);
        cyc(4);
        check("all4_x", 32'(x_m), 319);
        check("all4_moving_later", 32'(mv_m), 0);

        // Choice change with coincident ch1 strobe: FLUSH, strobe dropped.
        do_reset();
        Reset = 1'b0;
        cyc(1);
        strobe(3'b001, 3'b000, 3'b000, 3'b000, 3'b001);
        check("pre_flush_moving", 32'(mv_m), 1);
        Choice = 2'd1;
        strobe(3'b010, 3'b000, 3'b000, 3'b000, 3'b010);
        check("flush_moving", 32'(mv_m), 0);
        cyc(1);
        check("after_flush_moving", 32'(mv_m), 0);
        cyc(6);
        check("flush_x", 32'(x_m), 320);
        check("flush_moving_later", 32'(mv_m), 0);
        check("flush_step", 32'(st_m), 0);

        // Channel 1 now drives motion; channel 0 strobes are ignored.
        strobe(3'b011, 3'b000, 3'b000, 3'b010, 3'b001);
        check("ch1_moving", 32'(mv_m), 1);
        cyc(4);
        check("ch1_x", 32'(x_m), 319);

        // Out-of-range Choice: FLUSH, then every strobe ignored.
        Choice = 2'd3;
        cyc(3);
        strobe(3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
        cyc(6);
        check("oor_moving", 32'(mv_m), 0);
        check("oor_x", 32'(x_m), 319);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
